// File: rtl/link_split_mux.sv
// Multi-channel link split mux: per-channel tx FIFOs with a round-robin arbiter
// driving one valid/ready frame port, plus an id-checked rx fan-out to per-channel registers.

module lsm_ch_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen,
   input  logic              pop,
   input  logic [DATA_W-1:0] token,
   input  logic [DATA_W-1:0] clk_cnt,
   output logic              not_empty,
   output logic              full,
   output logic              drop,
   output logic [DATA_W-1:0] rd_token,
   output logic [DATA_W-1:0] rd_clk_cnt
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [DEPTH-1:0][2*DATA_W-1:0] mem;
   logic [AW-1:0]                  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]               count;
   logic                           push;

   assign full       = (count == CNT_W'(DEPTH));
   assign not_empty  = (count != '0);
   // A full FIFO still takes the write when the arbiter drains it on the same edge
   assign push       = wen && (!full || pop);
   assign drop       = wen && full && !pop;
   assign rd_token   = mem[rd_ptr][2*DATA_W-1:DATA_W];
   assign rd_clk_cnt = mem[rd_ptr][DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {token, clk_cnt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end
endmodule

module link_split_mux #(
   parameter int N_CH       = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int ID_BASE    = 0,
   localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic [N_CH-1:0]          i_wen_down,
   input  logic [N_CH*DATA_W-1:0]   i_token_down,
   input  logic [N_CH*DATA_W-1:0]   i_clk_cnt_down,
   output logic [N_CH-1:0]          o_full_down,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   output logic [CH_W-1:0]          o_tx_ch,
   output logic [DATA_W-1:0]        o_tx_token,
   output logic [DATA_W-1:0]        o_tx_clk_cnt,
   output logic [DATA_W-1:0]        o_tx_id,
   input  logic                     i_rx_valid,
   input  logic [CH_W-1:0]          i_rx_ch,
   input  logic [DATA_W-1:0]        i_rx_token,
   input  logic [DATA_W-1:0]        i_rx_clk_cnt,
   input  logic [DATA_W-1:0]        i_rx_id,
   output logic [N_CH-1:0]          o_wen_down,
   output logic [N_CH*DATA_W-1:0]   o_token_down,
   output logic [N_CH*DATA_W-1:0]   o_clk_cnt_down,
   output logic [N_CH*DATA_W-1:0]   o_id_down,
   output logic [15:0]              o_drop_cnt,
   output logic                     o_rx_err
);
   logic [N_CH-1:0][DATA_W-1:0] tok_in, cnt_in, fifo_tok, fifo_cnt;
   logic [N_CH-1:0][DATA_W-1:0] rx_tok, rx_cnt, rx_id;
   logic [N_CH-1:0]             not_empty, full, drop, pop;
   logic [CH_W-1:0]             ptr, grant;
   logic                        found, load, rx_ok;
   int                          idx;
   logic [4:0]                  drop_sum;
   logic [16:0]                 drop_add;
   logic [DATA_W-1:0]           rx_exp_id;

   assign tok_in = i_token_down;
   assign cnt_in = i_clk_cnt_down;

   lsm_ch_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo [N_CH-1:0] (
      .clk(i_clk), .rst_n(i_rstn), .wen(i_wen_down), .pop(pop),
      .token(tok_in), .clk_cnt(cnt_in), .not_empty(not_empty), .full(full),
      .drop(drop), .rd_token(fifo_tok), .rd_clk_cnt(fifo_cnt)
   );

   // First non-empty channel at or after the pointer, searching modulo N_CH
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N_CH; i++) begin
         idx = (int'(ptr) + i) % N_CH;
         if (!found && not_empty[idx]) begin
            grant = CH_W'(idx);
            found = 1'b1;
         end
      end
   end

   assign load = (!o_tx_valid || i_tx_ready) && found;

   always_comb begin
      pop = '0;
      if (load) pop[grant] = 1'b1;
   end

   always_comb begin
      drop_sum = '0;
      for (int i = 0; i < N_CH; i++) drop_sum = drop_sum + 5'(drop[i]);
   end
   assign drop_add = {1'b0, o_drop_cnt} + 17'(drop_sum);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ptr          <= '0;
         o_tx_valid   <= 1'b0;
         o_tx_ch      <= '0;
         o_tx_token   <= '0;
         o_tx_clk_cnt <= '0;
         o_tx_id      <= '0;
         o_drop_cnt   <= '0;
      end else begin
         if (load) begin
            o_tx_valid   <= 1'b1;
            o_tx_ch      <= grant;
            o_tx_token   <= fifo_tok[grant];
            o_tx_clk_cnt <= fifo_cnt[grant];
            o_tx_id      <= DATA_W'(ID_BASE) + DATA_W'(grant) + DATA_W'(1);
            ptr          <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
         end else if (i_tx_ready) begin
            o_tx_valid   <= 1'b0;
         end
         o_drop_cnt <= drop_add[16] ? 16'hFFFF : drop_add[15:0];
      end
   end

   assign o_full_down = full;

   assign rx_exp_id = DATA_W'(ID_BASE) + DATA_W'(i_rx_ch);
   assign rx_ok     = i_rx_valid && (int'(i_rx_ch) < N_CH) && (i_rx_id == rx_exp_id);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_wen_down <= '0;
         o_rx_err   <= 1'b0;
         rx_tok     <= '0;
         rx_cnt     <= '0;
         rx_id      <= '0;
      end else begin
         o_wen_down <= '0;
         if (rx_ok) begin
            o_wen_down[i_rx_ch] <= 1'b1;
            rx_tok[i_rx_ch]     <= i_rx_token;
            rx_cnt[i_rx_ch]     <= i_rx_clk_cnt;
            rx_id[i_rx_ch]      <= i_rx_id;
         end else if (i_rx_valid) begin
            o_rx_err <= 1'b1;
         end
      end
   end

   assign o_token_down   = rx_tok;
   assign o_clk_cnt_down = rx_cnt;
   assign o_id_down      = rx_id;
endmodule

// File: tb/tb_link_split_mux.sv
// Directed self-checking bench for link_split_mux with the default 4-channel configuration.

module tb_link_split_mux;
   localparam int N_CH = 4;
   localparam int DW   = 32;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [N_CH-1:0]   wen_down = '0;
   logic [N_CH*DW-1:0] token_down = '0, clk_cnt_down = '0;
   logic [N_CH-1:0]   full_down;
   logic              tx_valid, tx_ready = 1'b0;
   logic [1:0]        tx_ch;
   logic [DW-1:0]     tx_token, tx_clk_cnt, tx_id;
   logic              rx_valid = 1'b0;
   logic [1:0]        rx_ch = '0;
   logic [DW-1:0]     rx_token = '0, rx_clk_cnt = '0, rx_id = '0;
   logic [N_CH-1:0]   wen_up;
   logic [N_CH*DW-1:0] tok_up, cnt_up, id_up;
   logic [15:0]       drop_cnt;
   logic              rx_err;

   int n_chk = 0;
   int n_fail = 0;

   link_split_mux dut (
      .i_clk(clk), .i_rstn(rstn), .i_wen_down(wen_down), .i_token_down(token_down),
      .i_clk_cnt_down(clk_cnt_down), .o_full_down(full_down), .o_tx_valid(tx_valid),
      .i_tx_ready(tx_ready), .o_tx_ch(tx_ch), .o_tx_token(tx_token),
      .o_tx_clk_cnt(tx_clk_cnt), .o_tx_id(tx_id), .i_rx_valid(rx_valid),
      .i_rx_ch(rx_ch), .i_rx_token(rx_token), .i_rx_clk_cnt(rx_clk_cnt),
      .i_rx_id(rx_id), .o_wen_down(wen_up), .o_token_down(tok_up),
      .o_clk_cnt_down(cnt_up), .o_id_down(id_up), .o_drop_cnt(drop_cnt),
      .o_rx_err(rx_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      wen_down = '0;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_token", tx_token, 0);
      chk("rst_full", full_down, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_wen_up", wen_up, 0);
      chk("rst_rx_err", rx_err, 0);
      chk("rst_tok_up", tok_up, 0);
      step();
      rstn = 1'b1;

      // single write on channel 2
      tx_ready = 1'b1;
      wen_down = 4'b0100;
      token_down[2*DW +: DW]   = 32'hA5;
      clk_cnt_down[2*DW +: DW] = 32'd7;
      step();
      wen_down = '0;
      chk("single_lat_k", tx_valid, 0);
      step();
      chk("single_valid", tx_valid, 1);
      chk("single_ch", tx_ch, 2);
      chk("single_token", tx_token, 32'hA5);
      chk("single_clk_cnt", tx_clk_cnt, 7);
      chk("single_id", tx_id, 3);
      step();
      chk("single_idle", tx_valid, 0);
      chk("single_hold", tx_token, 32'hA5);

      // round robin from a fresh pointer
      do_reset();
      tx_ready = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         token_down[c*DW +: DW]   = 32'h10 + c;
         clk_cnt_down[c*DW +: DW] = 32'h20 + c;
      end
      wen_down = 4'b1111;
      step();
      wen_down = '0;
      for (int c = 0; c < N_CH; c++) begin
         step();
         chk("rr_valid", tx_valid, 1);
         chk("rr_ch", tx_ch, c);
         chk("rr_token", tx_token, 32'h10 + c);
         chk("rr_id", tx_id, c + 1);
      end
      step();
      chk("rr_idle", tx_valid, 0);

      // overflow on channel 1 with a stalled transport
      do_reset();
      wen_down = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         token_down[1*DW +: DW] = 32'h100 + i;
         step();
      end
      chk("ovf_valid", tx_valid, 1);
      chk("ovf_hold_token", tx_token, 32'h100);
      chk("ovf_full", full_down, 4'b0010);
      chk("ovf_drop", drop_cnt, 1);
      // full FIFO accepts a write on the edge that pops it
      tx_ready = 1'b1;
      token_down[1*DW +: DW] = 32'h1FF;
      step();
      wen_down = '0;
      chk("ovf_pp_full", full_down, 4'b0010);
      chk("ovf_pp_drop", drop_cnt, 1);
      chk("ovf_out1", tx_token, 32'h101);
      for (int i = 2; i < 5; i++) begin
         step();
         chk("ovf_out", tx_token, 32'h100 + i);
         chk("ovf_ch", tx_ch, 1);
      end
      step();
      chk("ovf_last", tx_token, 32'h1FF);
      chk("ovf_last_valid", tx_valid, 1);
      step();
      chk("ovf_drain", tx_valid, 0);

      // several channels dropping in the same cycle
      do_reset();
      wen_down = 4'b1111;
      for (int i = 0; i < 6; i++) step();
      wen_down = '0;
      chk("mdrop_cnt", drop_cnt, 7);
      chk("mdrop_full", full_down, 4'b1111);

      // rx fan-out and error
      do_reset();
      rx_valid = 1'b1; rx_ch = 2'd1; rx_id = 32'd1;
      rx_token = 32'h55; rx_clk_cnt = 32'h66;
      step();
      rx_valid = 1'b0;
      chk("rx_wen", wen_up, 4'b0010);
      chk("rx_tok1", tok_up[1*DW +: DW], 32'h55);
      chk("rx_cnt1", cnt_up[1*DW +: DW], 32'h66);
      chk("rx_id1", id_up[1*DW +: DW], 1);
      step();
      chk("rx_wen_pulse", wen_up, 0);
      chk("rx_tok_held", tok_up[1*DW +: DW], 32'h55);
      rx_valid = 1'b1; rx_ch = 2'd3; rx_id = 32'd3; rx_token = 32'h33;
      step();
      chk("rx_wen3", wen_up, 4'b1000);
      chk("rx_tok3", tok_up[3*DW +: DW], 32'h33);
      chk("rx_tok1_keep", tok_up[1*DW +: DW], 32'h55);
      rx_ch = 2'd1; rx_id = 32'd9; rx_token = 32'h77;
      step();
      rx_valid = 1'b0;
      chk("rx_err", rx_err, 1);
      chk("rx_err_wen", wen_up, 0);
      chk("rx_err_tok", tok_up[1*DW +: DW], 32'h55);
      step();
      chk("rx_err_sticky", rx_err, 1);

      // asynchronous reset mid-operation
      wen_down = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         token_down[0 +: DW] = 32'h200 + i;
         step();
      end
      wen_down = '0;
      chk("mid_valid_pre", tx_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_valid", tx_valid, 0);
      chk("mid_token", tx_token, 0);
      chk("mid_tok_up", tok_up, 0);
      chk("mid_rx_err", rx_err, 0);
      chk("mid_drop", drop_cnt, 0);
      step();
      rstn = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_no_stale", tx_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/link_split_mux.md
Name:
link_split_mux

Overview:
- Parametrised, multi-channel successor to the single-wen link split interface in the distributed-sim fringe layer.
- Transmit: collects N_CH downstream link channels into per-channel FIFOs, arbitrates round-robin and emits one tagged frame at a time over a valid/ready transport port toward the fringe put side.
- Receive: validates tagged frames from the fringe get side and fans them back out to per-channel registered outputs.
- Adds buffering, backpressure, drop accounting and ID checking.

Parameters:
- N_CH, 4, number of link channels (1..16).
- DATA_W, 32, width of token, clk_cnt and id fields.
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2).
- ID_BASE, 0, node id. A tx frame for channel c carries id ID_BASE+c+1. An rx frame for channel c must carry id ID_BASE+c.

Ports:
- i_clk in 1: clock.
- i_rstn in 1: reset. Asynchronous assert, active-low.
- i_wen_down in N_CH: per-channel write strobe.
- i_token_down in N_CH*DATA_W: per-channel token, channel c at [c*DATA_W +: DATA_W].
- i_clk_cnt_down in N_CH*DATA_W: per-channel clock count, same packing.
- o_full_down out N_CH: channel FIFO full.
- o_tx_valid out 1: tx frame valid.
- i_tx_ready in 1: transport accepts frame.
- o_tx_ch out $clog2(N_CH) (min 1): channel of tx frame.
- o_tx_token out DATA_W, o_tx_clk_cnt out DATA_W, o_tx_id out DATA_W: tx payload.
- i_rx_valid in 1: rx frame valid. No backpressure; always accepted.
- i_rx_ch in $clog2(N_CH): rx channel.
- i_rx_token in DATA_W, i_rx_clk_cnt in DATA_W, i_rx_id in DATA_W: rx payload.
- o_wen_down out N_CH: per-channel one-cycle receive strobe.
- o_token_down out N_CH*DATA_W, o_clk_cnt_down out N_CH*DATA_W, o_id_down out N_CH*DATA_W: per-channel held rx payload.
- o_drop_cnt out 16: saturating count of dropped tx writes.
- o_rx_err out 1: sticky rx error.

Behaviour:
- Reset (i_rstn low, asynchronous): all FIFOs empty, arbiter pointer=0. o_tx_valid=0 and all o_tx_* fields=0. o_wen_down=0, all o_*_down payloads=0, o_full_down=0, o_drop_cnt=0, o_rx_err=0. Reset mid-frame discards the pending frame and all FIFO contents with no replay.
- FIFO push:
  - i_wen_down[c]=1 with count<FIFO_DEPTH pushes {token, clk_cnt}.
  - At count==FIFO_DEPTH the push is still accepted if the same edge pops channel c; otherwise it is dropped and o_drop_cnt increments, saturating at 0xFFFF.
  - Multiple channels dropping in one cycle add their number of drops, saturating.
- o_full_down[c] = (count==FIFO_DEPTH), registered.
- Tx register load:
  - Loads when (!o_tx_valid || i_tx_ready) and at least one FIFO is non-empty.
  - Grant goes to the first non-empty channel at or after the pointer, modulo N_CH.
  - The load pops that FIFO and sets pointer = grant+1, wrapping to 0 after N_CH-1.
  - If no FIFO is non-empty and i_tx_ready=1, o_tx_valid goes to 0 and the payload holds its last value.
- Tx handshake:
  - Frame transfers on an edge where o_tx_valid && i_tx_ready.
  - While o_tx_valid && !i_tx_ready, all o_tx_* are held stable.
  - Back-to-back frames every cycle when i_tx_ready stays 1.
- Tx latency: word pushed at edge k into an empty FIFO with an idle tx register appears on o_tx_* after edge k+1.
- Tx payload: o_tx_id = ID_BASE+grant+1, truncated to DATA_W.
- Rx acceptance:
  - On an edge with i_rx_valid=1, i_rx_ch<N_CH and i_rx_id==ID_BASE+i_rx_ch, set o_wen_down[i_rx_ch]=1 for exactly one cycle.
  - Load that channel's token/clk_cnt/id outputs at the same edge; they hold until the next valid frame for that channel.
- Rx error: i_rx_valid with out-of-range channel or mismatched id sets o_rx_err=1 (sticky until reset); no output changes.
- Rx is independent of tx; simultaneous tx and rx activity is allowed every cycle.
- No combinational path from any input to any output.

Test Plan:
- Single write: reset, i_wen_down[2]=1 token=0xA5 clk_cnt=7, i_tx_ready=1 → after edge k+1, o_tx_valid=1, o_tx_ch=2, o_tx_token=0xA5, o_tx_clk_cnt=7, o_tx_id=3.
- Round-robin: all 4 channels written the same cycle, ready=1 → o_tx_ch sequence 0,1,2,3 on consecutive cycles, then o_tx_valid=0.
- Overflow and stall: i_tx_ready=0, channel 1 written 6 cycles → first tx frame loaded and held stable; FIFO fills; o_full_down[1]=1; o_drop_cnt=1. Release ready → 5 frames out in order.
- Rx: i_rx_valid ch=1 id=1 token=0x55 → o_wen_down=4'b0010 for one cycle and o_token_down[1]=0x55 held. Then ch=1 id=9 → o_rx_err=1, outputs unchanged.
- Reset mid-operation: assert i_rstn low asynchronously while o_tx_valid=1 and FIFOs hold 3 entries → all outputs 0 immediately. After release, no stale frames appear.
